seizure_alarm: RTL



---
 rtl/seizure_pkg.sv | 16 +
 rtl/sat_counter.sv | 45 ++++
 rtl/seizure_alarm.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seizure_pkg.sv
// Shared definitions for the seizure detection chain: FSM state encoding
// and default debounce parameters used by the detector top level.
package seizure_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ONSET   = 2'd1,
    ST_ALARM   = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  localparam int DEF_ONSET_CNT = 3;
  localparam int DEF_CLEAR_CNT = 5;
  localparam int DEF_MIN_HOLD  = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. A clear and an increment in the same cycle load
// the value 1, which lets the FSM restart a run with a single strobe pair.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] base_s;

  // Next count: optional clear first, then a capped increment.
  always_comb begin
    base_s = q_q;
    q_d    = q_q;
    if (clear) begin
      base_s = '0;
    end else begin
      base_s = q_q;
    end
    if (inc && (base_s < max)) begin
      q_d = base_s + WIDTH'(1);
    end else begin
      q_d = base_s;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seizure_alarm.sv
// Onset/recovery debounce of the per-window seizure decision into a latched
// alarm, with a sticky acknowledged interrupt and a saturating event count.
module seizure_alarm
  import seizure_pkg::*;
#(
  parameter int ONSET_CNT = DEF_ONSET_CNT,
  parameter int CLEAR_CNT = DEF_CLEAR_CNT,
  parameter int MIN_HOLD  = DEF_MIN_HOLD,
  parameter int CNT_WIDTH = 8,
  parameter int EVT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sample,
  input  logic                 seizure,
  input  logic                 ack,
  output logic                 alarm,
  output logic                 irq,
  output logic [EVT_WIDTH-1:0] event_count,
  output logic [1:0]           state
);

  state_e state_q, state_d;
  logic   alarm_q, alarm_d;
  logic   irq_q, irq_d;

  logic step_s, entry_s;
  logic run_clr_s, run_inc_s, hold_clr_s, hold_inc_s, neg_clr_s, neg_inc_s;
  logic [CNT_WIDTH-1:0] run_s, hold_s, neg_s;

  // en is active low: windows only advance while it is deasserted.
  assign step_s = sample & ~en;

  // Next-state, counter strobes and event entry.
  always_comb begin
    state_d    = state_q;
    entry_s    = 1'b0;
    run_clr_s  = 1'b0;
    run_inc_s  = 1'b0;
    hold_clr_s = 1'b0;
    hold_inc_s = 1'b0;
    neg_clr_s  = 1'b0;
    neg_inc_s  = 1'b0;
    if (step_s) begin
      case (state_q)
        ST_IDLE: begin
          if (seizure) begin
            run_clr_s = 1'b1;
            run_inc_s = 1'b1;
            if (ONSET_CNT == 1) begin
              state_d = ST_ALARM;
              entry_s = 1'b1;
            end else begin
              state_d = ST_ONSET;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ONSET: begin
          if (seizure) begin
            run_inc_s = 1'b1;
            if (run_s == CNT_WIDTH'(ONSET_CNT - 1)) begin
              state_d = ST_ALARM;
              entry_s = 1'b1;
            end else begin
              state_d = ST_ONSET;
            end
          end else begin
            run_clr_s = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_ALARM: begin
          if (hold_s < CNT_WIDTH'(MIN_HOLD)) begin
            hold_inc_s = 1'b1;
          end else if (!seizure) begin
            if (CLEAR_CNT == 1) begin
              state_d    = ST_IDLE;
              run_clr_s  = 1'b1;
              hold_clr_s = 1'b1;
              neg_clr_s  = 1'b1;
            end else begin
              state_d   = ST_RECOVER;
              neg_clr_s = 1'b1;
              neg_inc_s = 1'b1;
            end
          end else begin
            state_d = ST_ALARM;
          end
        end
        ST_RECOVER: begin
          if (seizure) begin
            // A relapse resumes the same event: hold and event count untouched.
            neg_clr_s = 1'b1;
            state_d   = ST_ALARM;
          end else if (neg_s == CNT_WIDTH'(CLEAR_CNT - 1)) begin
            state_d    = ST_IDLE;
            run_clr_s  = 1'b1;
            hold_clr_s = 1'b1;
            neg_clr_s  = 1'b1;
          end else begin
            neg_inc_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    if (entry_s) begin
      hold_clr_s = 1'b1;
    end else begin
      hold_clr_s = hold_clr_s;
    end
  end

  // Registered outputs; irq set takes precedence over a same-cycle ack.
  always_comb begin
    alarm_d = (state_d == ST_ALARM) || (state_d == ST_RECOVER);
    if (entry_s) begin
      irq_d = 1'b1;
    end else if (ack) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      alarm_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alarm_q <= alarm_d;
      irq_q   <= irq_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_run (
    .clk(clk), .rst(rst), .clear(run_clr_s), .inc(run_inc_s),
    .max(CNT_WIDTH'(ONSET_CNT)), .q(run_s)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hold (
    .clk(clk), .rst(rst), .clear(hold_clr_s), .inc(hold_inc_s),
    .max(CNT_WIDTH'(MIN_HOLD)), .q(hold_s)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_neg (
    .clk(clk), .rst(rst), .clear(neg_clr_s), .inc(neg_inc_s),
    .max(CNT_WIDTH'(CLEAR_CNT)), .q(neg_s)
  );

  sat_counter #(.WIDTH(EVT_WIDTH)) u_evt (
    .clk(clk), .rst(rst), .clear(1'b0), .inc(entry_s),
    .max({EVT_WIDTH{1'b1}}), .q(event_count)
  );

  assign alarm = alarm_q;
  assign irq   = irq_q;
  assign state = state_q;

endmodule
